pht_sat_table: RTL and testbench

//  Pattern history table of CNT_WIDTH-bit saturating counters with NUM_RD

---
 rtl/bpu_pkg.sv | 20 ++
 rtl/pht_ram.sv | 27 ++
 rtl/pht_sat_table.sv | 142 ++++++++++++++
 tb/tb_pht_sat_table.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/bpu_pkg.sv
// Shared branch-prediction types: PHT counter type, saturating-update helper
// and the PHT init/ready state encoding.
package bpu_pkg;

  localparam int PHT_CNT_WIDTH = 2;

  typedef logic [PHT_CNT_WIDTH-1:0] pht_cnt_t;

  typedef enum logic {
    PHT_INIT,
    PHT_READY
  } pht_state_e;

  // Saturating step: never wraps past all-ones or zero.
  function automatic pht_cnt_t pht_sat_next(input pht_cnt_t cnt, input logic taken);
    if (taken) return (cnt == '1) ? cnt : cnt + pht_cnt_t'(1);
    else       return (cnt == '0) ? cnt : cnt - pht_cnt_t'(1);
  endfunction

endpackage

// File: rtl/pht_ram.sv
// Counter storage: one write port, NUM_PORTS synchronous read ports.
// A read of the entry being written in the same cycle returns the old contents.
module pht_ram #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 2,
  parameter int NUM_PORTS  = 3
) (
  input  logic                            clk,
  input  logic                            we,
  input  logic [ADDR_WIDTH-1:0]           waddr,
  input  logic [DATA_WIDTH-1:0]           wdata,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] raddr,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    for (int i = 0; i < NUM_PORTS; i++) begin
      rdata[i*DATA_WIDTH +: DATA_WIDTH] <= mem[raddr[i*ADDR_WIDTH +: ADDR_WIDTH]];
    end
  end

endmodule

// File: rtl/pht_sat_table.sv
// Pattern history table of saturating counters with an init sweep and a
// 3-stage read-modify-write training pipe. Define PHT_RD_FWD_EN to let
// prediction reads see the value being written in the same cycle.
module pht_sat_table
  import bpu_pkg::*;
#(
  parameter int                   ADDR_WIDTH = 8,
  parameter int                   CNT_WIDTH  = PHT_CNT_WIDTH,
  parameter int                   NUM_RD     = 2,
  parameter logic [CNT_WIDTH-1:0] INIT_VAL   = CNT_WIDTH'((1 << (CNT_WIDTH - 1)) - 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic                         ready_o,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_index_i,
  output logic [NUM_RD*CNT_WIDTH-1:0]  rd_cnt_o,
  output logic [NUM_RD-1:0]            rd_taken_o,
  input  logic                         upd_valid_i,
  input  logic [ADDR_WIDTH-1:0]        upd_index_i,
  input  logic                         upd_taken_i
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = '1;

  pht_state_e            state, state_nxt;
  logic [ADDR_WIDTH-1:0] ptr, ptr_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= PHT_INIT;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    if (state == PHT_INIT) begin
      ptr_nxt = ptr + 1'b1;
      if (ptr == LAST_IDX) state_nxt = PHT_READY;
    end
  end

  assign ready_o = (state == PHT_READY);

  // Update handshake: upd_valid_i is a one-cycle request with no ready back;
  // it is taken whenever the table is ready and rst is low, otherwise dropped.
  logic                  upd_acc;
  logic                  u1_valid, u1_taken;
  logic [ADDR_WIDTH-1:0] u1_index;
  logic [CNT_WIDTH-1:0]  u1_old, u1_new;
  logic                  u2_valid, u3_valid;
  logic [ADDR_WIDTH-1:0] u2_index, u3_index;
  logic [CNT_WIDTH-1:0]  u2_data, u3_data;

  assign upd_acc = upd_valid_i && ready_o && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      u1_valid <= 1'b0;
      u2_valid <= 1'b0;
      u3_valid <= 1'b0;
    end else begin
      u1_valid <= upd_acc;
      u2_valid <= u1_valid;
      u3_valid <= u2_valid;
    end
    u1_index <= upd_index_i;
    u1_taken <= upd_taken_i;
    u2_index <= u1_index;
    u2_data  <= u1_new;
    u3_index <= u2_index;
    u3_data  <= u2_data;
  end

  logic [(NUM_RD+1)*CNT_WIDTH-1:0] ram_rdata;
  logic                            ram_we;
  logic [ADDR_WIDTH-1:0]           ram_waddr;
  logic [CNT_WIDTH-1:0]            ram_wdata;

  // U3 covers the write that landed while this update's array read was in flight.
  always_comb begin
    u1_old = ram_rdata[NUM_RD*CNT_WIDTH +: CNT_WIDTH];
    if (u3_valid && u3_index == u1_index) u1_old = u3_data;
    if (u2_valid && u2_index == u1_index) u1_old = u2_data;
    u1_new = CNT_WIDTH'(pht_sat_next(pht_cnt_t'(u1_old), u1_taken));
  end

  assign ram_we    = (state == PHT_INIT) || (u2_valid && !rst);
  assign ram_waddr = (state == PHT_INIT) ? ptr : u2_index;
  assign ram_wdata = (state == PHT_INIT) ? INIT_VAL : u2_data;

  pht_ram #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(CNT_WIDTH),
    .NUM_PORTS (NUM_RD + 1)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(ram_waddr),
    .wdata(ram_wdata),
    .raddr({upd_index_i, rd_index_i}),
    .rdata(ram_rdata)
  );

  // rd_live marks that the read issued last cycle hit a fully initialised table.
  logic rd_live;
  always_ff @(posedge clk) begin
    if (rst) rd_live <= 1'b0;
    else     rd_live <= ready_o;
  end

`ifdef PHT_RD_FWD_EN
  logic [NUM_RD-1:0]    fwd_hit;
  logic [CNT_WIDTH-1:0] fwd_data;
  always_ff @(posedge clk) begin
    for (int p = 0; p < NUM_RD; p++) begin
      fwd_hit[p] <= u2_valid && (u2_index == rd_index_i[p*ADDR_WIDTH +: ADDR_WIDTH]);
    end
    fwd_data <= u2_data;
  end
`endif

  logic [CNT_WIDTH-1:0] rd_cnt [NUM_RD];

  always_comb begin
    rd_cnt_o   = '0;
    rd_taken_o = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      rd_cnt[p] = rd_live ? ram_rdata[p*CNT_WIDTH +: CNT_WIDTH] : INIT_VAL;
`ifdef PHT_RD_FWD_EN
      if (rd_live && fwd_hit[p]) rd_cnt[p] = fwd_data;
`endif
      rd_cnt_o[p*CNT_WIDTH +: CNT_WIDTH] = rd_cnt[p];
      rd_taken_o[p]                      = rd_cnt[p][CNT_WIDTH-1];
    end
  end

endmodule

// File: tb/tb_pht_sat_table.sv
// Directed bench for pht_sat_table (ADDR_WIDTH=4, CNT_WIDTH=2, NUM_RD=2);
// honours PHT_RD_FWD_EN in its reference model.
module tb_pht_sat_table;

  localparam int AW = 4;
  localparam int CW = 2;
  localparam int NR = 2;
  localparam int N  = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             ready;
  logic [NR*AW-1:0] rd_index;
  logic [NR*CW-1:0] rd_cnt;
  logic [NR-1:0]    rd_taken;
  logic             upd_valid;
  logic [AW-1:0]    upd_index;
  logic             upd_taken;

  always #5 clk = ~clk;

  pht_sat_table #(
    .ADDR_WIDTH(AW),
    .CNT_WIDTH (CW),
    .NUM_RD    (NR)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ready_o    (ready),
    .rd_index_i (rd_index),
    .rd_cnt_o   (rd_cnt),
    .rd_taken_o (rd_taken),
    .upd_valid_i(upd_valid),
    .upd_index_i(upd_index),
    .upd_taken_i(upd_taken)
  );

  int total = 0;
  int bad   = 0;

  logic [CW-1:0] exp_q [$];

  // mdl: array contents as written; arch: value after all accepted updates.
  logic [CW-1:0] mdl  [N];
  logic [CW-1:0] arch [N];
  logic          p1_v = 1'b0, p2_v = 1'b0;
  logic [AW-1:0] p1_i, p2_i;
  logic [CW-1:0] p1_d, p2_d;
  int            init_left = N;

  function automatic logic [CW-1:0] sat(input logic [CW-1:0] c, input logic t);
    if (t) return (c == 2'b11) ? c : c + 2'd1;
    else   return (c == 2'b00) ? c : c - 2'd1;
  endfunction

  task automatic chk(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, predict outputs, advance the model, then compare.
  task automatic cyc(input logic [AW-1:0] r0, input logic [AW-1:0] r1, input logic uv,
                     input logic [AW-1:0] ui, input logic ut, input logic r);
    logic [CW-1:0] e;
    logic [AW-1:0] idx;
    logic          acc;
    rst       = r;
    rd_index  = {r1, r0};
    upd_valid = uv;
    upd_index = ui;
    upd_taken = ut;
    for (int p = 0; p < NR; p++) begin
      idx = (p == 0) ? r0 : r1;
      e   = mdl[idx];
`ifdef PHT_RD_FWD_EN
      if (p2_v && p2_i == idx) e = p2_d;
`endif
      if (r || init_left > 0) e = 2'b01;
      exp_q.push_back(e);
    end
    acc = uv && !r && (init_left == 0);
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < N; i++) begin
        mdl[i]  = 2'b01;
        arch[i] = 2'b01;
      end
      p1_v      = 1'b0;
      p2_v      = 1'b0;
      init_left = N;
    end else if (init_left > 0) begin
      init_left--;
    end else begin
      if (p2_v) mdl[p2_i] = p2_d;
      p2_v = p1_v;
      p2_i = p1_i;
      p2_d = p1_d;
      p1_v = acc;
      if (acc) begin
        arch[ui] = sat(arch[ui], ut);
        p1_i     = ui;
        p1_d     = arch[ui];
      end
    end
    #1;
    for (int p = 0; p < NR; p++) begin
      e = exp_q.pop_front();
      chk($sformatf("rd_cnt%0d", p), rd_cnt[p*CW +: CW], e);
      chk($sformatf("rd_taken%0d", p), {1'b0, rd_taken[p]}, {1'b0, e[CW-1]});
    end
    chk("ready", {1'b0, ready}, {1'b0, logic'(init_left == 0)});
  endtask

  task automatic rd(input logic [AW-1:0] r0, input logic [AW-1:0] r1);
    cyc(r0, r1, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic up(input logic [AW-1:0] ui, input logic ut,
                    input logic [AW-1:0] r0, input logic [AW-1:0] r1);
    cyc(r0, r1, 1'b1, ui, ut, 1'b0);
  endtask

  initial begin
    // 1: reset, init sweep, every entry weakly not-taken
    cyc(0, 0, 1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < N; i++) rd(AW'(i), AW'(N - 1 - i));
    chk("t1_ready", {1'b0, ready}, 2'b01);
    for (int i = 0; i < N; i++) begin
      rd(AW'(i), AW'(N - 1 - i));
      chk("t1_init", rd_cnt[1:0], 2'b01);
      chk("t1_taken", {1'b0, rd_taken[0]}, 2'b00);
    end

    // 2: saturate up on idx 5, hold at top, saturate down, no wrap
    for (int k = 0; k < 3; k++) up(5, 1'b1, 5, 5);
    for (int k = 0; k < 3; k++) rd(5, 5);
    chk("t2_up3", rd_cnt[1:0], 2'b11);
    up(5, 1'b1, 5, 5);
    for (int k = 0; k < 3; k++) rd(5, 5);
    chk("t2_sat_hi", rd_cnt[3:2], 2'b11);
    for (int k = 0; k < 4; k++) up(5, 1'b0, 5, 5);
    for (int k = 0; k < 3; k++) rd(5, 5);
    chk("t2_sat_lo", rd_cnt[1:0], 2'b00);

    // 3: alternating back-to-back updates to idx 3, watched on port 1
    for (int k = 0; k < 10; k++) up(3, (k % 2) == 0, 0, 3);
    for (int k = 0; k < 3; k++) rd(3, 3);
    chk("t3_final", rd_cnt[3:2], 2'b01);

    // 4: port independence
    rd(7, 7);
    chk("t4_same", rd_cnt[3:2], rd_cnt[1:0]);
    rd(2, 9);
    rd(5, 3);

    // 5: read during the U2 write of a taken update on idx 4
    up(4, 1'b1, 0, 0);
    rd(0, 0);
    rd(4, 4);
`ifdef PHT_RD_FWD_EN
    chk("t5_wr_cycle", rd_cnt[1:0], 2'b10);
`else
    chk("t5_wr_cycle", rd_cnt[1:0], 2'b01);
`endif
    rd(4, 4);
    chk("t5_after", rd_cnt[1:0], 2'b10);

    // 6: reset with updates in flight, updates offered during init
    up(6, 1'b1, 6, 6);
    up(6, 1'b1, 6, 6);
    cyc(6, 6, 1'b1, 6, 1'b1, 1'b1);
    for (int i = 0; i < N; i++) cyc(AW'(i), 6, 1'b1, 6, 1'b1, 1'b0);
    chk("t6_ready", {1'b0, ready}, 2'b01);
    for (int i = 0; i < N; i++) begin
      rd(AW'(i), AW'(N - 1 - i));
      chk("t6_reinit0", rd_cnt[1:0], 2'b01);
      chk("t6_reinit1", rd_cnt[3:2], 2'b01);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
